// File: rtl/rwt_sample_unpack.sv
`default_nettype none
//==============================================================================
//  Module   : rwt_sample_unpack
//  Purpose  : Transmit-path inverse of the sample packer. Accepts 64-bit
//             beats holding two packed 32-bit samples (first in [63:32],
//             second in [31:0]) and re-spreads them onto the two-channel
//             slot layout (ch0 = [31:0], ch1 = [63:32]) according to the
//             channel enables captured when each beat is accepted.
//
//  Modes (captured per beat at input acceptance):
//             BOTH : both channels on  -> word passes through as one beat
//             ONE0 : ch0 only          -> two beats, samples in ch0 slot
//             ONE1 : ch1 only          -> two beats, samples in ch1 slot
//             NONE : no channel on     -> word accepted and discarded
//
//  Build option:
//             RWT_SAMPLE_UNPACK_DUP_EN  defined   : in single-channel modes
//                                                   the idle slot carries a
//                                                   copy of the live sample
//                                       undefined : idle slot is 32'd0
//
//  Parameters:
//             UWIDTH        width of the user sideband (passed through)
//
//  Ports:
//             clk           clock
//             aresetn       synchronous, active-low reset
//             enables       {ch1_q, ch1_i, ch0_q, ch0_i}
//             s_axi_*       packed input stream (valid/ready/data/user/last)
//             m_axi_*       slot-aligned output stream
//                           (valid/ready/data/enables/user/last)
//
//  Revision : 1.0  initial release
//==============================================================================

module rwt_sample_unpack #(
    parameter int UWIDTH = 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [3:0]        enables,

    output logic              s_axi_ready,
    input  logic              s_axi_valid,
    input  logic [63:0]       s_axi_data,
    input  logic [UWIDTH-1:0] s_axi_user,
    input  logic              s_axi_last,

    input  logic              m_axi_ready,
    output logic              m_axi_valid,
    output logic [63:0]       m_axi_data,
    output logic [3:0]        m_axi_enables,
    output logic [UWIDTH-1:0] m_axi_user,
    output logic              m_axi_last
);

    //--------------------------------------------------------------------------
    // State encoding
    //   EMPTY : nothing held
    //   FULL  : BOTH-mode word held, emitted as a single beat
    //   HI    : single-channel word held, emitting its first sample ([63:32])
    //   LO    : single-channel word held, emitting its second sample ([31:0])
    //--------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HI    = 2'd2,
        ST_LO    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    state_t            accept_state;

    // Holding register
    logic [63:0]       held_data;
    logic [UWIDTH-1:0] held_user;
    logic              held_last;
    logic              held_ch1;      // single-channel target: 1 = ch1, 0 = ch0

    logic              ch0_on;
    logic              ch1_on;
    logic              accept;
    logic              load;
    logic              drain_ok;      // current beat is leaving this cycle and
                                      // the holding register frees up behind it

    logic [31:0]       live_sample;
    logic [31:0]       idle_slot;

    //--------------------------------------------------------------------------
    // Input-side handshake
    //--------------------------------------------------------------------------
    assign ch0_on = |enables[1:0];
    assign ch1_on = |enables[3:2];

    // HI never frees the register: the second half still has to go out.
    assign drain_ok = ((state == ST_FULL) || (state == ST_LO)) && m_axi_ready;

    // Ready depends only on state, downstream ready and reset -- never on
    // s_axi_valid -- so no combinational valid->ready loop can form upstream.
    assign s_axi_ready = aresetn && ((state == ST_EMPTY) || drain_ok);

    assign accept = s_axi_valid && s_axi_ready;

    // A NONE-mode word is consumed but never stored, so the held contents
    // only change for words that will actually produce output.
    assign load   = accept && (ch0_on || ch1_on);

    //--------------------------------------------------------------------------
    // Next state
    //--------------------------------------------------------------------------
    always_comb begin
        accept_state = ST_EMPTY;
        if (ch0_on && ch1_on) begin
            accept_state = ST_FULL;
        end else if (ch0_on || ch1_on) begin
            accept_state = ST_HI;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = accept_state;
                end
            end
            ST_FULL, ST_LO: begin
                // Back-to-back reload when a new word is taken in the same
                // cycle the current beat drains.
                if (m_axi_ready) begin
                    state_nxt = accept ? accept_state : ST_EMPTY;
                end
            end
            ST_HI: begin
                if (m_axi_ready) begin
                    state_nxt = ST_LO;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // State and holding register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            held_data <= 64'd0;
            held_user <= '0;
            held_last <= 1'b0;
            held_ch1  <= 1'b0;
        end else if (load) begin
            held_data <= s_axi_data;
            held_user <= s_axi_user;
            held_last <= s_axi_last;
            // Only meaningful for single-channel words; ignored in FULL.
            held_ch1  <= ch1_on && !ch0_on;
        end
    end

    //--------------------------------------------------------------------------
    // Output decode
    //   Outputs are a pure function of the state and the holding register,
    //   so they stay stable while the beat is stalled by m_axi_ready.
    //--------------------------------------------------------------------------
    assign live_sample = (state == ST_LO) ? held_data[31:0] : held_data[63:32];

`ifdef RWT_SAMPLE_UNPACK_DUP_EN
    assign idle_slot = live_sample;
`else
    assign idle_slot = 32'd0;
`endif

    always_comb begin
        m_axi_valid   = 1'b0;
        m_axi_data    = 64'd0;
        m_axi_enables = 4'd0;
        m_axi_user    = '0;
        m_axi_last    = 1'b0;
        case (state)
            ST_FULL: begin
                m_axi_valid   = 1'b1;
                m_axi_data    = held_data;
                m_axi_enables = 4'b1111;
                m_axi_user    = held_user;
                m_axi_last    = held_last;
            end
            ST_HI, ST_LO: begin
                m_axi_valid = 1'b1;
                m_axi_user  = held_user;
                // End-of-packet belongs to the second half only.
                m_axi_last  = (state == ST_LO) && held_last;
                if (held_ch1) begin
                    m_axi_data    = {live_sample, idle_slot};
                    m_axi_enables = 4'b1100;
                end else begin
                    m_axi_data    = {idle_slot, live_sample};
                    m_axi_enables = 4'b0011;
                end
            end
            default: begin
                m_axi_valid = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rwt_sample_unpack.sv
`default_nettype none
//==============================================================================
//  Module   : tb_rwt_sample_unpack
//  Purpose  : Directed self-checking bench for rwt_sample_unpack.
//             Inputs change just after the falling edge; outputs are checked
//             at the following falling edge, away from the active edge.
//  Revision : 1.0  initial release
//==============================================================================

module tb_rwt_sample_unpack;

    localparam int UWIDTH = 1;

    localparam logic [63:0] WORD_A = 64'hAAAA0001_AAAA0002;
    localparam logic [63:0] WORD_B = 64'hBBBB0003_BBBB0004;
    localparam logic [63:0] WORD_W = 64'h11112222_33334444;
    localparam logic [63:0] WORD_C = 64'hC0FFEE00_DEADBEEF;

`ifdef RWT_SAMPLE_UNPACK_DUP_EN
    localparam logic [63:0] EXP_ONE0_HI = 64'h11112222_11112222;
    localparam logic [63:0] EXP_ONE0_LO = 64'h33334444_33334444;
    localparam logic [63:0] EXP_ONE1_HI = 64'h11112222_11112222;
    localparam logic [63:0] EXP_ONE1_LO = 64'h33334444_33334444;
`else
    localparam logic [63:0] EXP_ONE0_HI = 64'h00000000_11112222;
    localparam logic [63:0] EXP_ONE0_LO = 64'h00000000_33334444;
    localparam logic [63:0] EXP_ONE1_HI = 64'h11112222_00000000;
    localparam logic [63:0] EXP_ONE1_LO = 64'h33334444_00000000;
`endif

    logic              clk = 1'b0;
    logic              aresetn;
    logic [3:0]        enables;
    logic              s_axi_ready;
    logic              s_axi_valid;
    logic [63:0]       s_axi_data;
    logic [UWIDTH-1:0] s_axi_user;
    logic              s_axi_last;
    logic              m_axi_ready;
    logic              m_axi_valid;
    logic [63:0]       m_axi_data;
    logic [3:0]        m_axi_enables;
    logic [UWIDTH-1:0] m_axi_user;
    logic              m_axi_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rwt_sample_unpack #(
        .UWIDTH (UWIDTH)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .enables       (enables),
        .s_axi_ready   (s_axi_ready),
        .s_axi_valid   (s_axi_valid),
        .s_axi_data    (s_axi_data),
        .s_axi_user    (s_axi_user),
        .s_axi_last    (s_axi_last),
        .m_axi_ready   (m_axi_ready),
        .m_axi_valid   (m_axi_valid),
        .m_axi_data    (m_axi_data),
        .m_axi_enables (m_axi_enables),
        .m_axi_user    (m_axi_user),
        .m_axi_last    (m_axi_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One full clock: the rising edge, then return at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Check a complete output beat.
    task automatic check_beat(input string tag, input logic [63:0] data,
                              input logic [3:0] en, input logic last,
                              input logic [UWIDTH-1:0] user);
        check({tag, ".valid"}, {63'd0, m_axi_valid}, 64'd1);
        check({tag, ".data"},  m_axi_data, data);
        check({tag, ".en"},    {60'd0, m_axi_enables}, {60'd0, en});
        check({tag, ".last"},  {63'd0, m_axi_last}, {63'd0, last});
        check({tag, ".user"},  {{(64-UWIDTH){1'b0}}, m_axi_user}, {{(64-UWIDTH){1'b0}}, user});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, {63'd0, m_axi_valid}, 64'd0);
        check({tag, ".data"},  m_axi_data, 64'd0);
        check({tag, ".en"},    {60'd0, m_axi_enables}, 64'd0);
        check({tag, ".last"},  {63'd0, m_axi_last}, 64'd0);
        check({tag, ".user"},  {{(64-UWIDTH){1'b0}}, m_axi_user}, 64'd0);
    endtask

    task automatic check_sready(input string tag, input logic exp);
        #1;
        check(tag, {63'd0, s_axi_ready}, {63'd0, exp});
    endtask

    initial begin
        aresetn     = 1'b0;
        enables     = 4'h0;
        s_axi_valid = 1'b0;
        s_axi_data  = 64'd0;
        s_axi_user  = '0;
        s_axi_last  = 1'b0;
        m_axi_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check_idle_outputs("rst");
        check_sready("rst.sready", 1'b0);
        aresetn = 1'b1;
        check_sready("rst.release_sready", 1'b1);

        // ---------------- 1: BOTH, back-to-back ----------------
        enables     = 4'hF;
        m_axi_ready = 1'b1;
        s_axi_valid = 1'b1;
        s_axi_data  = WORD_A;
        s_axi_user  = 1'b1;
        s_axi_last  = 1'b0;
        step();
        check_beat("both.A", WORD_A, 4'hF, 1'b0, 1'b1);
        check_sready("both.A_sready", 1'b1);
        s_axi_data = WORD_B;
        s_axi_user = 1'b0;
        s_axi_last = 1'b1;
        step();
        check_beat("both.B", WORD_B, 4'hF, 1'b1, 1'b0);
        s_axi_valid = 1'b0;
        step();
        check("both.drain_valid", {63'd0, m_axi_valid}, 64'd0);

        // ---------------- 2: ONE0 ----------------
        enables     = 4'h3;
        s_axi_valid = 1'b1;
        s_axi_data  = WORD_W;
        s_axi_user  = 1'b1;
        s_axi_last  = 1'b1;
        step();
        check_beat("one0.hi", EXP_ONE0_HI, 4'h3, 1'b0, 1'b1);
        s_axi_valid = 1'b0;
        check_sready("one0.hi_sready", 1'b0);
        step();
        check_beat("one0.lo", EXP_ONE0_LO, 4'h3, 1'b1, 1'b1);
        step();
        check("one0.drain_valid", {63'd0, m_axi_valid}, 64'd0);

        // ---------------- 3: ONE1 with backpressure ----------------
        enables     = 4'hC;
        m_axi_ready = 1'b0;
        s_axi_valid = 1'b1;
        s_axi_data  = WORD_W;
        s_axi_user  = 1'b0;
        s_axi_last  = 1'b1;
        step();
        check_beat("one1.hi", EXP_ONE1_HI, 4'hC, 1'b0, 1'b0);
        // Enables change must not disturb the held word.
        s_axi_valid = 1'b0;
        enables     = 4'h0;
        check_sready("one1.hi_sready", 1'b0);
        step();
        check_beat("one1.hi_stall", EXP_ONE1_HI, 4'hC, 1'b0, 1'b0);
        m_axi_ready = 1'b1;
        check_sready("one1.hi_sready_rdy", 1'b0);
        step();
        check_beat("one1.lo", EXP_ONE1_LO, 4'hC, 1'b1, 1'b0);
        m_axi_ready = 1'b0;
        check_sready("one1.lo_sready_stall", 1'b0);
        step();
        check_beat("one1.lo_stall", EXP_ONE1_LO, 4'hC, 1'b1, 1'b0);
        m_axi_ready = 1'b1;
        check_sready("one1.lo_sready_rdy", 1'b1);
        step();
        check("one1.drain_valid", {63'd0, m_axi_valid}, 64'd0);

        // ---------------- 4: NONE, then enables mid-stream ----------------
        enables     = 4'h0;
        s_axi_valid = 1'b1;
        s_axi_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_axi_data = 64'h0000_0000_0000_0100 + 64'(i);
            check_sready($sformatf("none.w%0d_sready", i), 1'b1);
            step();
            check($sformatf("none.w%0d_valid", i), {63'd0, m_axi_valid}, 64'd0);
        end
        enables    = 4'hF;
        s_axi_data = WORD_C;
        s_axi_user = 1'b1;
        s_axi_last = 1'b1;
        step();
        check_beat("none.pass", WORD_C, 4'hF, 1'b1, 1'b1);
        s_axi_valid = 1'b0;
        step();
        check("none.drain_valid", {63'd0, m_axi_valid}, 64'd0);

        // ---------------- 5: reset while in HI ----------------
        enables     = 4'h3;
        s_axi_valid = 1'b1;
        s_axi_data  = WORD_W;
        s_axi_user  = 1'b1;
        s_axi_last  = 1'b1;
        step();
        check_beat("rsthi.hi", EXP_ONE0_HI, 4'h3, 1'b0, 1'b1);
        s_axi_valid = 1'b0;
        aresetn     = 1'b0;
        step();
        check_idle_outputs("rsthi.in_rst");
        check_sready("rsthi.sready_in_rst", 1'b0);
        aresetn = 1'b1;
        check_sready("rsthi.sready_release", 1'b1);
        step();
        check("rsthi.no_second_half", {63'd0, m_axi_valid}, 64'd0);
        step();
        check("rsthi.still_idle", {63'd0, m_axi_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
